npu_wb_array: RTL and testbench

- Parametrised successor of the fixed 3x3 Wishbone NPU.
- An N x N weight-stationary systolic array of signed multiply-accumulate PEs, attached to the Caravel Wishbone slave bus on a single clock.
- Adds:
  - an input vector FIFO with automatic input skew and output deskew;
  - a run/drain state machine and a packed result buffer;
  - a status register with sticky error flags;
  - a uniform single-cycle ack for every access.

---
 rtl/npu_pkg.sv | 31 +++
 rtl/npu_pe_p.sv | 40 ++++
 rtl/npu_wb_array.sv | 258 +++++++++++++++++++++++++
 tb/tb_npu_wb_array.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared constants, state enum and helpers for npu_wb_array
package npu_pkg;

  // Region offsets inside the 1 KB window (byte offset = wb_adr_i[9:0])
  localparam logic [9:0] REG_CTRL = 10'h000;
  localparam logic [9:0] REG_W    = 10'h100;
  localparam logic [9:0] REG_IN   = 10'h200;
  localparam logic [9:0] REG_OUT  = 10'h300;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  // STATUS read bits
  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_EMPTY  = 3;
  localparam int ST_OVF    = 4;
  localparam int ST_IN_OVF = 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/npu_pe_p.sv
// rtl/npu_pe_p.sv - weight-stationary signed MAC processing element
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_left, i_w       activation from the left, stationary weight
//   i_up              partial sum from the PE above
//   o_right, o_down   registered activation / partial sum outputs
module npu_pe_p #(
  parameter int IW    = 8,
  parameter int ACC_W = 18
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic signed [IW-1:0]    i_left,
  input  logic signed [IW-1:0]    i_w,
  input  logic signed [ACC_W-1:0] i_up,
  output logic signed [IW-1:0]    o_right,
  output logic signed [ACC_W-1:0] o_down
);

  logic signed [2*IW-1:0]  w_prod;
  logic signed [IW-1:0]    r_right;
  logic signed [ACC_W-1:0] r_down;

  assign w_prod = i_left * i_w;

  // Product is sign-extended to ACC_W; the sum wraps, no saturation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_right <= '0;
      r_down  <= '0;
    end else begin
      r_right <= i_left;
      r_down  <= i_up + ACC_W'(w_prod);
    end
  end

  assign o_right = r_right;
  assign o_down  = r_down;

endmodule

// File: rtl/npu_wb_array.sv
// rtl/npu_wb_array.sv - N x N systolic MAC array on a Wishbone slave
// Ports:
//   wb_clk_i, wb_rst_i   single clock, synchronous active-high reset
//   wb_stb_i, wb_cyc_i   bus strobe / cycle
//   wb_we_i, wb_sel_i    write enable, byte select (ignored)
//   wb_adr_i, wb_dat_i   byte address, write data
//   wb_ack_o, wb_dat_o   one-cycle ack, registered read data
module npu_wb_array
  import npu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          N          = 3,
  parameter int          IW         = 8,
  parameter int          ACC_W      = 18,
  parameter int          FIFO_DEPTH = 16,
  parameter int          OUT_ROWS   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  input  logic [31:0] wb_adr_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o
);

  localparam int VW  = N * IW;
  localparam int FAW = clog2(FIFO_DEPTH);
  localparam int FCW = FAW + 1;
  localparam int OCW = clog2(OUT_ROWS + 1);
  localparam int PL  = 2 * N;
  localparam int IFW = clog2(PL + 1);

  logic                    r_ack;
  logic [31:0]             r_dat;
  state_t                  r_state;
  logic [FAW-1:0]          r_wp, r_rp;
  logic [FCW-1:0]          r_fcnt;
  logic [OCW-1:0]          r_oc;
  logic [IFW-1:0]          r_infl;
  logic                    r_done, r_ovf, r_in_ovf;
  logic [PL-1:0]           r_vp;
  logic [VW-1:0]           r_fifo [FIFO_DEPTH];
  logic signed [IW-1:0]    r_w [N*N];
  logic signed [ACC_W-1:0] r_obuf [OUT_ROWS][N];

  logic [9:0]              w_off;
  logic                    w_req, w_wr, w_rd;
  logic                    w_sel_ctrl, w_sel_in, w_sel_w, w_sel_out;
  logic                    w_busy, w_start, w_clear;
  logic                    w_fempty, w_ffull, w_pop, w_push, w_push_ok, w_out_v;
  logic [VW-1:0]           w_head;
  logic signed [ACC_W-1:0] w_res;
  logic [31:0]             w_status, w_rdata;
  logic                    w_unused;

  // ---------------------------------------------------------------- decode
  assign w_off      = wb_adr_i[9:0];
  assign w_req      = wb_stb_i & wb_cyc_i & (wb_adr_i[31:10] == BASE_ADDR[31:10]) & ~r_ack;
  assign w_wr       = w_req & wb_we_i;
  assign w_rd       = w_req & ~wb_we_i;
  assign w_sel_ctrl = (w_off == REG_CTRL);
  assign w_sel_in   = (w_off == REG_IN);
  assign w_sel_w    = (w_off[9:8] == REG_W[9:8]);
  assign w_sel_out  = (w_off[9:8] == REG_OUT[9:8]);
  assign w_unused   = ^{wb_sel_i, wb_dat_i, w_off[1:0]};

  // ---------------------------------------------------------------- control
  assign w_busy    = (r_state == RUN) || (r_state == DRAIN);
  assign w_clear   = w_wr & w_sel_ctrl & (r_state == IDLE) & wb_dat_i[CTRL_CLEAR];
  assign w_start   = w_wr & w_sel_ctrl & (r_state == IDLE) & wb_dat_i[CTRL_START];
  assign w_fempty  = (r_fcnt == '0);
  assign w_ffull   = (r_fcnt == FCW'(FIFO_DEPTH));
  assign w_pop     = (r_state == RUN) & ~w_fempty;
  assign w_push    = w_wr & w_sel_in;
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands
  assign w_push_ok = w_push & (~w_ffull | w_pop);
  assign w_out_v   = r_vp[PL-1];
  assign w_head    = r_fifo[r_rp];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= IDLE;
      r_wp     <= '0;
      r_rp     <= '0;
      r_fcnt   <= '0;
      r_oc     <= '0;
      r_infl   <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_in_ovf <= 1'b0;
      r_vp     <= '0;
    end else begin
      if (w_clear) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_fcnt <= '0;
      end else begin
        if (w_push_ok) r_wp <= r_wp + 1'b1;
        if (w_pop)     r_rp <= r_rp + 1'b1;
        r_fcnt <= r_fcnt + FCW'(w_push_ok) - FCW'(w_pop);
      end
      if (w_push && !w_push_ok) r_in_ovf <= 1'b1;

      r_vp   <= {r_vp[PL-2:0], w_pop};
      r_infl <= r_infl + IFW'(w_pop) - IFW'(w_out_v);
      if (w_out_v) begin
        if (r_oc < OCW'(OUT_ROWS)) r_oc <= r_oc + 1'b1;
        else                       r_ovf <= 1'b1;
      end

      case (r_state)
        IDLE:  if (w_start) r_state <= (w_clear || w_fempty) ? DRAIN : RUN;
        RUN:   if (w_fempty) r_state <= DRAIN;
        DRAIN: if (r_infl == '0) begin
                 r_state <= DONE;
                 r_done  <= 1'b1;
               end
        default: r_state <= IDLE;
      endcase

      // CLEAR is applied before START when both bits are written together
      if (w_clear) begin
        r_oc     <= '0;
        r_done   <= 1'b0;
        r_ovf    <= 1'b0;
        r_in_ovf <= 1'b0;
      end
      if (w_start) begin
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push_ok) r_fifo[r_wp] <= wb_dat_i[VW-1:0];
  end

  // Weights only change outside RUN/DRAIN so a run sees a stable matrix
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < N*N; k++) r_w[k] <= '0;
    end else if (w_wr && w_sel_w && !w_busy) begin
      for (int k = 0; k < N*N; k++)
        if (w_off[7:2] == 6'(k)) r_w[k] <= $signed(wb_dat_i[IW-1:0]);
    end
  end

  // ---------------------------------------------------------------- array
  logic signed [IW-1:0]    w_h [N][N+1];
  logic signed [ACC_W-1:0] w_v [N+1][N];
  logic signed [ACC_W-1:0] w_col [N];

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      // Lane gi enters row gi after gi extra cycles of skew
      logic signed [IW-1:0] r_sk [0:gi];
      logic                 w_unused_right;
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          for (int d = 0; d <= gi; d++) r_sk[d] <= '0;
        end else begin
          r_sk[0] <= w_pop ? $signed(w_head[gi*IW +: IW]) : '0;
          for (int d = 1; d <= gi; d++) r_sk[d] <= r_sk[d-1];
        end
      end
      assign w_h[gi][0]     = r_sk[gi];
      assign w_unused_right = ^w_h[gi][N];

      for (gj = 0; gj < N; gj++) begin : g_col
        npu_pe_p #(.IW(IW), .ACC_W(ACC_W)) u_pe (
          .i_clk   (wb_clk_i),
          .i_rst   (wb_rst_i),
          .i_left  (w_h[gi][gj]),
          .i_w     (r_w[gi*N + gj]),
          .i_up    (w_v[gi][gj]),
          .o_right (w_h[gi][gj+1]),
          .o_down  (w_v[gi+1][gj])
        );
      end
    end

    for (gj = 0; gj < N; gj++) begin : g_dsk
      assign w_v[0][gj] = '0;
      // Column gj is delayed N-1-gj cycles so the whole row lines up
      if (gj == N-1) begin : g_last
        assign w_col[gj] = w_v[N][gj];
      end else begin : g_dly
        logic signed [ACC_W-1:0] r_dk [0:N-2-gj];
        always_ff @(posedge wb_clk_i) begin
          if (wb_rst_i) begin
            for (int d = 0; d <= N-2-gj; d++) r_dk[d] <= '0;
          end else begin
            r_dk[0] <= w_v[N][gj];
            for (int d = 1; d <= N-2-gj; d++) r_dk[d] <= r_dk[d-1];
          end
        end
        assign w_col[gj] = r_dk[N-2-gj];
      end
    end
  endgenerate

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && w_out_v && r_oc < OCW'(OUT_ROWS)) begin
      for (int r = 0; r < OUT_ROWS; r++)
        if (r_oc == OCW'(r))
          for (int c = 0; c < N; c++) r_obuf[r][c] <= w_col[c];
    end
  end

  // ---------------------------------------------------------------- read path
  always_comb begin
    w_res = '0;
    for (int r = 0; r < OUT_ROWS; r++)
      for (int c = 0; c < N; c++)
        if (w_off[7:4] == 4'(r) && w_off[3:2] == 2'(c)) w_res = r_obuf[r][c];
  end

  always_comb begin
    w_status            = '0;
    w_status[ST_BUSY]   = w_busy;
    w_status[ST_DONE]   = r_done;
    w_status[ST_FULL]   = w_ffull;
    w_status[ST_EMPTY]  = w_fempty;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_IN_OVF] = r_in_ovf;
    w_status[15:8]      = 8'(r_oc);
    w_status[23:16]     = 8'(r_fcnt);
  end

  // Rows at or above out_count read as 0, including a row being written now
  always_comb begin
    w_rdata = '0;
    if (w_sel_ctrl)
      w_rdata = w_status;
    else if (w_sel_out && int'(w_off[7:4]) < int'(r_oc) && int'(w_off[3:2]) < N)
      w_rdata = 32'(w_res);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : '0;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;

endmodule

// File: tb/tb_npu_wb_array.sv
// tb/tb_npu_wb_array.sv - directed scoreboard bench for npu_wb_array
module tb_npu_wb_array;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] sb_q [$];
  string       tag_q [$];

  npu_wb_array dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_we_i  (we),
    .wb_sel_i (sel),
    .wb_dat_i (dat_i),
    .wb_adr_i (adr),
    .wb_ack_o (ack),
    .wb_dat_o (dat_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic acked);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
    acked = 1'b0;
    rd = '0;
    for (int k = 0; k < 8 && !acked; k++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        acked = 1'b1;
        rd = dat_o;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input string tag);
    logic [31:0] rd;
    logic        a;
    bus(1'b1, BASE + off, d, rd, a);
    chk({tag, " ack"}, {31'b0, a}, 32'd1);
  endtask

  task automatic rd_exp(input logic [31:0] off, input logic [31:0] exp, input string tag);
    logic [31:0] rd, e;
    logic        a;
    string       t;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    bus(1'b0, BASE + off, 32'h0, rd, a);
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    if (a) chk(t, rd, e);
    else   chk({t, " ack"}, {31'b0, a}, 32'd1);
  endtask

  task automatic push3(input int a, input int b, input int c);
    wr(32'h200, {8'h00, 8'(c), 8'(b), 8'(a)}, "push");
  endtask

  task automatic row_exp(input int r, input int c, input int v, input string tag);
    rd_exp(32'h300 + 32'(16*r + 4*c), 32'(v), tag);
  endtask

  task automatic poll_idle(input string tag);
    logic [31:0] rd;
    logic        a;
    bit          idle;
    idle = 1'b0;
    for (int k = 0; k < 100 && !idle; k++) begin
      bus(1'b0, BASE, 32'h0, rd, a);
      if (a && !rd[0]) idle = 1'b1;
    end
    chk({tag, " idle"}, {31'b0, idle}, 32'd1);
  endtask

  task automatic set_all_w(input int v);
    for (int k = 0; k < 9; k++) wr(32'h100 + 32'(4*k), 32'(v), "wset");
  endtask

  task automatic set_ident();
    for (int k = 0; k < 9; k++) wr(32'h100 + 32'(4*k), (k % 4 == 0) ? 32'd1 : 32'd0, "wid");
  endtask

  initial begin
    logic [31:0] rd;
    logic        a;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; dat_i = '0; adr = '0;
    repeat (3) @(negedge clk);
    chk("reset ack", {31'b0, ack}, 32'd0);
    chk("reset dat", dat_o, 32'd0);
    rst = 1'b0;
    rd_exp(32'h000, 32'h0000_0008, "reset status");

    // 1: identity weights, single vector, write lands 6 cycles after pop
    set_ident();
    push3(1, 2, 3);
    rd_exp(32'h000, 32'h0001_0000, "t1 queued");
    wr(32'h000, 32'h1, "t1 start");
    repeat (6) @(negedge clk);
    rd_exp(32'h000, 32'h0000_0009, "t1 before write");
    poll_idle("t1");
    rd_exp(32'h000, 32'h0000_010A, "t1 status");
    row_exp(0, 0, 1, "t1 r0c0");
    row_exp(0, 1, 2, "t1 r0c1");
    row_exp(0, 2, 3, "t1 r0c2");
    row_exp(1, 0, 0, "t1 r1 beyond count");

    // 2: all weights 2, positive and negative vectors
    wr(32'h000, 32'h2, "t2 clear");
    rd_exp(32'h000, 32'h0000_0008, "t2 cleared");
    set_all_w(2);
    push3(1, 2, 3);
    push3(-1, -2, -3);
    wr(32'h000, 32'h1, "t2 start");
    repeat (7) @(negedge clk);
    rd_exp(32'h000, 32'h0000_0109, "t2 first written");
    poll_idle("t2");
    rd_exp(32'h000, 32'h0000_020A, "t2 status");
    for (int c = 0; c < 3; c++) row_exp(0, c, 12, "t2 row0");
    for (int c = 0; c < 3; c++) rd_exp(32'h310 + 32'(4*c), 32'hFFFF_FFF4, "t2 row1");

    // 3: extreme negative operands, no wrap at 18 bits
    wr(32'h000, 32'h2, "t3 clear");
    set_all_w(-128);
    push3(-128, -128, -128);
    wr(32'h000, 32'h1, "t3 start");
    poll_idle("t3");
    for (int c = 0; c < 3; c++) row_exp(0, c, 49152, "t3 row0");

    // 4: input FIFO overflow, weight write ignored while running
    wr(32'h000, 32'h2, "t4 clear");
    set_ident();
    for (int k = 0; k < 17; k++) push3(k, k + 1, -k);
    rd_exp(32'h000, 32'h0010_0024, "t4 fifo full");
    wr(32'h000, 32'h1, "t4 start");
    wr(32'h100, 32'h5, "t4 busy wwrite");
    poll_idle("t4");
    rd_exp(32'h000, 32'h0000_102A, "t4 status");
    row_exp(0, 0, 0, "t4 r0c0");
    row_exp(0, 1, 1, "t4 r0c1");
    row_exp(15, 0, 15, "t4 r15c0");
    row_exp(15, 1, 16, "t4 r15c1");
    row_exp(15, 2, -15, "t4 r15c2");

    // 5: result buffer overflow across two runs
    wr(32'h000, 32'h2, "t5 clear");
    for (int k = 0; k < 10; k++) push3(k + 20, 0, 0);
    wr(32'h000, 32'h1, "t5 start a");
    poll_idle("t5a");
    for (int k = 10; k < 17; k++) push3(k + 20, 0, 0);
    wr(32'h000, 32'h1, "t5 start b");
    poll_idle("t5b");
    rd_exp(32'h000, 32'h0000_101A, "t5 status");
    row_exp(9, 0, 29, "t5 r9c0");
    row_exp(15, 0, 35, "t5 r15c0");
    row_exp(15, 1, 0, "t5 r15c1");
    wr(32'h000, 32'h2, "t5 clear2");
    rd_exp(32'h000, 32'h0000_0008, "t5 after clear");

    // 6: reset in the middle of a run
    for (int k = 0; k < 3; k++) push3(1, 1, 1);
    wr(32'h000, 32'h1, "t6 start");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_exp(32'h000, 32'h0000_0008, "t6 after reset");
    push3(1, 2, 3);
    wr(32'h000, 32'h1, "t6 start2");
    poll_idle("t6");
    rd_exp(32'h000, 32'h0000_010A, "t6 status");
    for (int c = 0; c < 3; c++) row_exp(0, c, 0, "t6 zero weights");
    rd_exp(32'h0F0, 32'h0, "unmapped read");
    rd_exp(32'h104, 32'h0, "weight read");
    rd_exp(32'h200, 32'h0, "push read");
    bus(1'b0, BASE + 32'h400, 32'h0, rd, a);
    chk("outside window no ack", {31'b0, a}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
